// File: rtl/counter_pkg.sv
// Shared types and helpers for the programmable-counter sweep sequencer.
package counter_pkg;

    typedef enum logic [1:0] {
        UP        = 2'd0,
        DOWN      = 2'd1,
        BOUNCE_UP = 2'd2,
        BOUNCE_DN = 2'd3
    } sweep_mode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DWELL = 3'd3,
        DONE  = 3'd4
    } sweep_state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    function automatic logic mode_is_bounce(input sweep_mode_t m);
        return (m == BOUNCE_UP) || (m == BOUNCE_DN);
    endfunction

    function automatic logic mode_start_dir(input sweep_mode_t m);
        return ((m == DOWN) || (m == BOUNCE_DN)) ? DIR_DN : DIR_UP;
    endfunction

endpackage

// File: rtl/counter_dwell_timer.sv
// Loadable down-counter for endpoint dwell; load beats freeze, expired is high at zero.
module counter_dwell_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             freeze,
    output logic             expired
);

    logic [WIDTH-1:0] count_r;

    // Count down toward zero unless frozen; hold at zero until reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (!freeze && (count_r != '0)) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == '0);

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer driving load/enable/dir of the 8-bit counter, with dwell and repeat control.
module counter_sweep_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 8,
    parameter int REPS_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   cfg_start,
    input  logic [WIDTH-1:0]   cfg_lo,
    input  logic [WIDTH-1:0]   cfg_hi,
    input  logic [1:0]         cfg_mode,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [REPS_W-1:0]  cfg_reps,
    input  logic               start,
    input  logic               abort,
    input  logic               hold,
    input  logic [WIDTH-1:0]   cnt_val,
    output logic               cnt_load,
    output logic [WIDTH-1:0]   cnt_load_val,
    output logic               cnt_enable,
    output logic               cnt_dir,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [REPS_W-1:0]  pass_cnt
);

    sweep_state_t       state_r, state_s;
    sweep_mode_t        mode_r;
    logic [WIDTH-1:0]   start_r, lo_r, hi_r, target_r, load_val_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [REPS_W-1:0]  reps_r, pass_r, pass_inc_s;
    logic               dir_r, load_r, busy_r, done_r, err_r;
    logic               sample_s, cfg_ok_s, start_dir_s, at_target_s;
    logic               accept_s, reject_s, arrive_s, expire_s;
    logic               freeze_s, tmr_expired_s;

    assign cfg_ok_s    = (cfg_lo <= cfg_hi) && (cfg_start >= cfg_lo) && (cfg_start <= cfg_hi);
    assign sample_s    = (state_r == IDLE) && start && !abort;
    assign start_dir_s = mode_start_dir(sweep_mode_t'(cfg_mode));
    assign at_target_s = (cnt_val == target_r);
    assign pass_inc_s  = pass_r + REPS_W'(1);
    assign freeze_s    = hold || (state_r != DWELL);

    counter_dwell_timer #(.WIDTH(DWELL_W)) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (arrive_s),
        .load_val (dwell_r),
        .freeze   (freeze_s),
        .expired  (tmr_expired_s)
    );

    // Next-state decode; abort overrides everything else.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        reject_s = 1'b0;
        arrive_s = 1'b0;
        expire_s = 1'b0;
        if (abort) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok_s) begin
                            accept_s = 1'b1;
                            state_s  = LOAD;
                        end else begin
                            reject_s = 1'b1;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                LOAD: state_s = RUN;
                RUN: begin
                    if (!hold && at_target_s) begin
                        arrive_s = 1'b1;
                        state_s  = DWELL;
                    end else begin
                        state_s = RUN;
                    end
                end
                DWELL: begin
                    if (!hold && tmr_expired_s) begin
                        expire_s = 1'b1;
                        if ((reps_r != '0) && (pass_inc_s == reps_r)) begin
                            state_s = DONE;
                        end else if (mode_is_bounce(mode_r)) begin
                            state_s = RUN;
                        end else begin
                            state_s = LOAD;
                        end
                    end else begin
                        state_s = DWELL;
                    end
                end
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // State register and strobes registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            load_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            load_r  <= (state_s == LOAD);
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
            err_r   <= reject_s;
        end
    end

    // Config snapshot taken whenever start is seen in IDLE, accepted or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_r <= '0;
            lo_r    <= '0;
            hi_r    <= '0;
            mode_r  <= UP;
            dwell_r <= '0;
            reps_r  <= '0;
        end else if (sample_s) begin
            start_r <= cfg_start;
            lo_r    <= cfg_lo;
            hi_r    <= cfg_hi;
            mode_r  <= sweep_mode_t'(cfg_mode);
            dwell_r <= cfg_dwell;
            reps_r  <= cfg_reps;
        end else begin
            start_r <= start_r;
        end
    end

    // Sweep datapath: a bounce turnaround flips direction and swaps the endpoint.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_val_r <= '0;
            pass_r     <= '0;
            dir_r      <= DIR_UP;
            target_r   <= '0;
        end else if (accept_s) begin
            load_val_r <= cfg_start;
            pass_r     <= '0;
            dir_r      <= start_dir_s;
            target_r   <= (start_dir_s == DIR_DN) ? cfg_lo : cfg_hi;
        end else if (expire_s) begin
            pass_r <= pass_inc_s;
            if (state_s == RUN) begin
                dir_r    <= ~dir_r;
                target_r <= (dir_r == DIR_UP) ? lo_r : hi_r;
            end else if (state_s == LOAD) begin
                load_val_r <= start_r;
            end else begin
                dir_r <= dir_r;
            end
        end else begin
            dir_r <= dir_r;
        end
    end

    // Enable is combinational so stepping stops exactly on the target.
    assign cnt_enable   = (state_r == RUN) && !hold && !abort && !at_target_s;
    assign cnt_load     = load_r;
    assign cnt_load_val = load_val_r;
    assign cnt_dir      = dir_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign cfg_err      = err_r;
    assign pass_cnt     = pass_r;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl with a behavioural model of the counter it drives.
module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cfg_start, cfg_lo, cfg_hi, cfg_dwell;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_reps;
    logic       start, abort, hold;
    logic [7:0] cnt_val;
    logic       cnt_load, cnt_enable, cnt_dir, busy, done, cfg_err;
    logic [7:0] cnt_load_val;
    logic [3:0] pass_cnt;
    logic [7:0] cnt_model;

    int n_tests = 0;
    int n_fail  = 0;
    int en_total = 0, en_dn_total = 0, load_total = 0, done_total = 0;

    always #5 clk = ~clk;

    counter_sweep_ctrl #(.WIDTH(8), .DWELL_W(8), .REPS_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_mode(cfg_mode),
        .cfg_dwell(cfg_dwell), .cfg_reps(cfg_reps),
        .start(start), .abort(abort), .hold(hold), .cnt_val(cnt_val),
        .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .cnt_enable(cnt_enable),
        .cnt_dir(cnt_dir), .busy(busy), .done(done), .cfg_err(cfg_err), .pass_cnt(pass_cnt)
    );

    // Model of the driven counter: load wins over enable, dir=1 decrements.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_model <= 8'd0;
        else if (cnt_load) cnt_model <= cnt_load_val;
        else if (cnt_enable) cnt_model <= cnt_dir ? cnt_model - 8'd1 : cnt_model + 8'd1;
    end
    assign cnt_val = cnt_model;

    // Running event totals sampled on the active edge.
    always @(posedge clk) begin
        if (cnt_enable) en_total <= en_total + 1;
        if (cnt_enable && cnt_dir) en_dn_total <= en_dn_total + 1;
        if (cnt_load) load_total <= load_total + 1;
        if (done) done_total <= done_total + 1;
    end

    task automatic set_cfg(input logic [7:0] s, input logic [7:0] lo, input logic [7:0] hi,
                           input logic [1:0] m, input logic [7:0] d, input logic [3:0] r);
        cfg_start = s; cfg_lo = lo; cfg_hi = hi; cfg_mode = m; cfg_dwell = d; cfg_reps = r;
    endtask

    task automatic launch(input logic [7:0] exp_val, input string tag);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        n_tests++;
        if (cnt_load !== 1'b1 || cnt_load_val !== exp_val || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_load: load=%b val=%0d busy=%b, expected load=1 val=%0d busy=1",
                     tag, cnt_load, cnt_load_val, busy, exp_val);
        end
    endtask

    // Steps cycles after LOAD until done; optional hold windows and busy-time disturbances.
    task automatic run_seq(input int limit, input int ha0, input int ha1, input int hb0, input int hb1,
                           input bit disturb, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            hold = ((i >= ha0) && (i <= ha1)) || ((i >= hb0) && (i <= hb1));
            if (disturb) begin
                start = 1'b1; cfg_hi = 8'd200; cfg_mode = 2'd3; cfg_reps = 4'd9; cfg_start = 8'd150;
            end
            #1;
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        hold = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({cnt_load, cnt_enable, cnt_dir, busy, done, cfg_err} !== 6'b0 ||
            cnt_load_val !== 8'd0 || pass_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ld=%b en=%b dir=%b busy=%b done=%b err=%b val=%0d pass=%0d, expected all 0",
                     cnt_load, cnt_enable, cnt_dir, busy, done, cfg_err, cnt_load_val, pass_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_up_once(input bit disturb, input string tag);
        int cyc, en_b, ld_b;
        set_cfg(8'd10, 8'd10, 8'd15, 2'd0, 8'd0, 4'd1);
        en_b = en_total; ld_b = load_total;
        launch(8'd10, tag);
        run_seq(50, -1, -1, -1, -1, disturb, cyc);
        n_tests++;
        if (cyc !== 8) begin n_fail++; $display("FAIL %s_cycles: got %0d, expected 8", tag, cyc); end
        n_tests++;
        if (cnt_model !== 8'd15 || pass_cnt !== 4'd1) begin
            n_fail++; $display("FAIL %s_end: cnt=%0d pass=%0d, expected cnt=15 pass=1", tag, cnt_model, pass_cnt);
        end
        @(negedge clk); #1;
        n_tests++;
        if (en_total - en_b !== 5 || load_total - ld_b !== 1) begin
            n_fail++; $display("FAIL %s_strobes: enables=%0d loads=%0d, expected 5 and 1", tag, en_total - en_b, load_total - ld_b);
        end
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL %s_idle: busy=%b done=%b, expected 0 0", tag, busy, done);
        end
    endtask

    task automatic test_bounce();
        int cyc, en_b, dn_b;
        set_cfg(8'd3, 8'd3, 8'd5, 2'd2, 8'd2, 4'd3);
        en_b = en_total; dn_b = en_dn_total;
        launch(8'd3, "bounce");
        run_seq(80, -1, -1, -1, -1, 1'b0, cyc);
        n_tests++;
        if (cyc !== 19) begin n_fail++; $display("FAIL bounce_cycles: got %0d, expected 19", cyc); end
        n_tests++;
        if (cnt_model !== 8'd5 || pass_cnt !== 4'd3 || cnt_dir !== 1'b0) begin
            n_fail++; $display("FAIL bounce_end: cnt=%0d pass=%0d dir=%b, expected 5 3 0", cnt_model, pass_cnt, cnt_dir);
        end
        @(negedge clk);
        n_tests++;
        if (en_total - en_b !== 6 || en_dn_total - dn_b !== 2) begin
            n_fail++; $display("FAIL bounce_steps: enables=%0d down=%0d, expected 6 and 2", en_total - en_b, en_dn_total - dn_b);
        end
    endtask

    task automatic test_cfg_err();
        int ld_b;
        for (int v = 0; v < 2; v++) begin
            if (v == 0) set_cfg(8'd10, 8'd20, 8'd10, 2'd0, 8'd0, 4'd1);
            else        set_cfg(8'd5, 8'd10, 8'd20, 2'd0, 8'd0, 4'd1);
            ld_b = load_total;
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0; #1;
            n_tests++;
            if (cfg_err !== 1'b1 || busy !== 1'b0 || cnt_load !== 1'b0) begin
                n_fail++; $display("FAIL cfg_err_pulse%0d: err=%b busy=%b load=%b, expected 1 0 0", v, cfg_err, busy, cnt_load);
            end
            @(negedge clk); #1;
            n_tests++;
            if (cfg_err !== 1'b0 || busy !== 1'b0 || load_total != ld_b) begin
                n_fail++; $display("FAIL cfg_err_after%0d: err=%b busy=%b loads=%0d, expected 0 0 0", v, cfg_err, busy, load_total - ld_b);
            end
        end
    endtask

    task automatic test_hold();
        int cyc, en_b;
        set_cfg(8'd10, 8'd10, 8'd15, 2'd0, 8'd3, 4'd1);
        en_b = en_total;
        launch(8'd10, "hold");
        run_seq(80, 3, 9, 15, 21, 1'b0, cyc);
        n_tests++;
        if (cyc !== 25) begin n_fail++; $display("FAIL hold_cycles: got %0d, expected 25", cyc); end
        @(negedge clk);
        n_tests++;
        if (en_total - en_b !== 5 || cnt_model !== 8'd15) begin
            n_fail++; $display("FAIL hold_steps: enables=%0d cnt=%0d, expected 5 and 15", en_total - en_b, cnt_model);
        end
    endtask

    task automatic test_single_point();
        int cyc, en_b;
        set_cfg(8'h80, 8'h80, 8'h80, 2'd3, 8'd0, 4'd2);
        en_b = en_total;
        launch(8'h80, "point");
        run_seq(30, -1, -1, -1, -1, 1'b0, cyc);
        n_tests++;
        if (cyc !== 5) begin n_fail++; $display("FAIL point_cycles: got %0d, expected 5", cyc); end
        n_tests++;
        if (cnt_model !== 8'h80 || pass_cnt !== 4'd2 || cnt_dir !== 1'b0 || en_total != en_b) begin
            n_fail++; $display("FAIL point_end: cnt=%0h pass=%0d dir=%b enables=%0d, expected 80 2 0 0",
                               cnt_model, pass_cnt, cnt_dir, en_total - en_b);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int seen, done_b;
        set_cfg(8'd8, 8'd0, 8'd8, 2'd1, 8'd0, 4'd0);
        done_b = done_total;
        launch(8'd8, "abort");
        seen = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk); #1;
            if (pass_cnt === 4'd4) begin seen = i; break; end
        end
        n_tests++;
        if (seen !== 44) begin n_fail++; $display("FAIL abort_pass4_time: got %0d, expected 44", seen); end
        repeat (3) @(negedge clk);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0; #1;
        n_tests++;
        if (busy !== 1'b0 || cnt_load !== 1'b0 || cnt_enable !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: busy=%b load=%b en=%b done=%b, expected all 0", busy, cnt_load, cnt_enable, done);
        end
        @(negedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || done_total != done_b) begin
            n_fail++; $display("FAIL abort_after: busy=%b dones=%0d, expected 0 0", busy, done_total - done_b);
        end
    endtask

    task automatic test_reset_midrun();
        set_cfg(8'd8, 8'd0, 8'd8, 2'd1, 8'd0, 4'd0);
        launch(8'd8, "rstmid");
        repeat (15) @(negedge clk);
        rst_n = 1'b0; #1;
        n_tests++;
        if (busy !== 1'b0 || pass_cnt !== 4'd0 || cnt_load_val !== 8'd0 || cnt_dir !== 1'b0 || cnt_enable !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_outputs: busy=%b pass=%0d val=%0d dir=%b en=%b, expected all 0",
                               busy, pass_cnt, cnt_load_val, cnt_dir, cnt_enable);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
        set_cfg(8'd0, 8'd0, 8'd0, 2'd0, 8'd0, 4'd0);
        test_reset();
        test_up_once(1'b0, "up_once");
        test_up_once(1'b1, "busy_ignore");
        test_bounce();
        test_cfg_err();
        test_hold();
        test_single_point();
        test_abort();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
